// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low with the dp bit set (dp off).
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Index 0 is the rightmost element of the concatenation.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] value;
    } digit_t;

    localparam digit_t DIGIT_RST = '{blank: 1'b1, dp: 1'b0, value: 4'h0};

    typedef enum logic {
        PH_GUARD,
        PH_DRIVE
    } phase_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit write port: valid/ready handshake carrying one shadow-register update.
interface seg_scan_ctrl_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_digit;
    logic [3:0] wr_value;
    logic       wr_dp;
    logic       wr_blank;

    modport master (
        output wr_valid, wr_digit, wr_value, wr_dp, wr_blank,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_digit, wr_value, wr_dp, wr_blank,
        output wr_ready
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble/dp/blank to active-low segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            seg    = HEX_SEG[value];
            seg[7] = ~dp;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with blanking guard per slot
// and shadow/active digit sets swapped atomically at frame wrap.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 500
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    seg_scan_ctrl_if.slave   wr,
    input  logic             commit,
    output logic             frame_done,
    output logic [3:0]       an,
    output logic [7:0]       seg
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      slot, slot_nxt;
    logic            pending, pending_nxt;
    digit_t [3:0]    shadow, shadow_nxt;
    digit_t [3:0]    active, active_nxt;
    logic [3:0]      an_nxt;
    logic [7:0]      seg_nxt, dec_seg;
    logic            frame_done_nxt;
    logic            cnt_wrap, frame_wrap, wr_fire, swap;
    phase_t          phase;

    assign wr.wr_ready = !pending;

    seg_hex_decode u_dec (
        .value (active[slot].value),
        .dp    (active[slot].dp),
        .blank (active[slot].blank),
        .seg   (dec_seg)
    );

    always_comb begin
        phase      = (cnt < CW'(GUARD)) ? PH_GUARD : PH_DRIVE;
        cnt_wrap   = (cnt == CW'(REFRESH_DIV - 1));
        frame_wrap = cnt_wrap && (slot == 2'd3);
        wr_fire    = wr.wr_valid && !pending;
        swap       = frame_wrap && (pending || commit);

        cnt_nxt  = cnt_wrap ? '0 : cnt + CW'(1);
        slot_nxt = cnt_wrap ? slot + 2'd1 : slot;

        // The swap copies shadow_nxt so a same-cycle write lands in the committed frame.
        shadow_nxt = shadow;
        if (wr_fire) begin
            shadow_nxt[wr.wr_digit] = '{blank: wr.wr_blank, dp: wr.wr_dp, value: wr.wr_value};
        end
        active_nxt = swap ? shadow_nxt : active;

        pending_nxt = pending;
        if (swap) begin
            pending_nxt = 1'b0;
        end else if (commit) begin
            pending_nxt = 1'b1;
        end
        frame_done_nxt = swap;

        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        if (phase == PH_DRIVE) begin
            an_nxt  = ~(4'b0001 << slot);
            seg_nxt = dec_seg;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            cnt        <= '0;
            slot       <= '0;
            pending    <= 1'b0;
            shadow     <= {4{DIGIT_RST}};
            active     <= {4{DIGIT_RST}};
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            slot       <= slot_nxt;
            pending    <= pending_nxt;
            shadow     <= shadow_nxt;
            active     <= active_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=8, GUARD=2.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       commit = 1'b0;
    logic       frame_done;
    logic [3:0] an;
    logic [7:0] seg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seg_scan_ctrl_if wr_if ();

    seg_scan_ctrl #(.REFRESH_DIV(8), .GUARD(2)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .wr             (wr_if),
        .commit         (commit),
        .frame_done     (frame_done),
        .an             (an),
        .seg            (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic wr(input logic [1:0] d, input logic [3:0] v, input logic dp);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_digit = d;
        wr_if.wr_value = v;
        wr_if.wr_dp    = dp;
        wr_if.wr_blank = 1'b0;
        step();
        wr_if.wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int pulse_cyc;
        int guard_cnt;
        int lit_cnt;
        logic [3:0] exp_an;
        logic [7:0] exp_seg [4];

        exp_seg[0] = 8'hF9;
        exp_seg[1] = 8'hA4;
        exp_seg[2] = 8'h30;
        exp_seg[3] = 8'h99;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_digit = '0;
        wr_if.wr_value = '0;
        wr_if.wr_dp    = 1'b0;
        wr_if.wr_blank = 1'b0;

        // Reset
        repeat (3) step();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 8'hFF);
        check("rst_ready", wr_if.wr_ready, 1'b1);
        check("rst_fdone", frame_done, 1'b0);
        rst = 1'b0;
        cyc = 0;
        step();
        check("c1_an", an, 4'hF);
        step();
        check("c2_an", an, 4'hF);
        step();
        check("c3_an", an, 4'hE);
        check("c3_seg", seg, 8'hFF);

        // Write 1,2,3.,4 then commit; swap at edge 32
        wr(2'd0, 4'h1, 1'b0);
        wr(2'd1, 4'h2, 1'b0);
        wr(2'd2, 4'h3, 1'b1);
        wr(2'd3, 4'h4, 1'b0);
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("commit_ready_low", wr_if.wr_ready, 1'b0);
        pulses = 0;
        pulse_cyc = -1;
        guard_cnt = 0;
        while (cyc < 64) begin
            step();
            if (frame_done) begin
                pulses++;
                if (pulse_cyc < 0) pulse_cyc = cyc;
            end
            if (cyc == 32) check("swap_ready_high", wr_if.wr_ready, 1'b1);
            if (cyc >= 33) begin
                exp_an = (((cyc - 1) % 8) < 2) ? 4'hF : ~(4'b0001 << (((cyc - 1) / 8) % 4));
                check("frame_an", an, exp_an);
                if (an == 4'hF) guard_cnt++;
                if (((cyc - 35) % 8) == 0)
                    check("frame_seg", seg, exp_seg[(cyc - 35) / 8]);
            end
        end
        check("fdone_pulses", pulses, 1);
        check("fdone_cycle", pulse_cyc, 32);
        check("guard_cycles", guard_cnt, 8);

        // Stall: commit then a write held until the swap
        run_to(65);
        commit = 1'b1;
        step();
        commit = 1'b0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_digit = 2'd0;
        wr_if.wr_value = 4'h5;
        wr_if.wr_dp    = 1'b0;
        wr_if.wr_blank = 1'b0;
        check("stall_ready66", wr_if.wr_ready, 1'b0);
        run_to(80);
        check("stall_ready80", wr_if.wr_ready, 1'b0);
        run_to(95);
        check("stall_fdone95", frame_done, 1'b0);
        step();
        check("stall_fdone96", frame_done, 1'b1);
        check("stall_ready96", wr_if.wr_ready, 1'b1);
        step();
        wr_if.wr_valid = 1'b0;
        run_to(99);
        check("stall_an99", an, 4'hE);
        check("stall_seg99", seg, 8'hF9);

        // Write + commit on the frame-wrap cycle (edge 128)
        run_to(127);
        check("wrap_fdone127", frame_done, 1'b0);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_digit = 2'd1;
        wr_if.wr_value = 4'hA;
        commit = 1'b1;
        step();
        wr_if.wr_valid = 1'b0;
        commit = 1'b0;
        check("wrap_fdone128", frame_done, 1'b1);
        check("wrap_ready128", wr_if.wr_ready, 1'b1);
        step();
        check("wrap_fdone129", frame_done, 1'b0);
        run_to(131);
        check("wrap_an131", an, 4'hE);
        check("wrap_seg131", seg, 8'h92);
        run_to(139);
        check("wrap_an139", an, 4'hD);
        check("wrap_seg139", seg, 8'h88);

        // Mid-frame reset with a commit pending
        run_to(169);
        commit = 1'b1;
        step();
        commit = 1'b0;
        run_to(180);
        check("pre_rst_ready", wr_if.wr_ready, 1'b0);
        check("pre_rst_an", an, 4'hB);
        check("pre_rst_seg", seg, 8'h30);
        rst = 1'b1;
        step();
        check("mrst_an", an, 4'hF);
        check("mrst_seg", seg, 8'hFF);
        check("mrst_ready", wr_if.wr_ready, 1'b1);
        check("mrst_fdone", frame_done, 1'b0);
        rst = 1'b0;
        cyc = 0;
        pulses = 0;
        lit_cnt = 0;
        while (cyc < 40) begin
            step();
            if (frame_done) pulses++;
            if (seg != 8'hFF) lit_cnt++;
            if (cyc == 3) check("post_rst_an3", an, 4'hE);
        end
        check("post_rst_pulses", pulses, 0);
        check("post_rst_lit", lit_cnt, 0);
        check("post_rst_ready", wr_if.wr_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the 4-digit seven-segment display on the `sky` board. It time-multiplexes the shared `an`/`seg` pins across four digits, and inserts a blanking guard at each digit change to suppress ghosting. Digit contents are written through a valid/ready port into shadow registers and swapped into the displayed set atomically at a frame boundary on `commit`. It sits between machine logic and the top-level `an`/`seg` pins.

## Interface
- `REFRESH_DIV`, default 50000: clocks per digit slot; must be ≥ 2.
- `GUARD`, default 500: blank clocks at the start of each slot; 1 ≤ `GUARD` < `REFRESH_DIV`.
- `system1000` in 1: clock.
- `system1000_rst` in 1: reset, synchronous, active-high.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted when `wr_valid && wr_ready`.
- `wr_digit` in 2: target digit 0..3.
- `wr_value` in 4: hex nibble.
- `wr_dp` in 1: decimal point on.
- `wr_blank` in 1: digit dark.
- `commit` in 1: request shadow→active swap at the next frame wrap.
- `frame_done` out 1: one-cycle pulse on the cycle a swap occurs.
- `an` out 4: digit enables, active-low; `an[i]` selects digit i.
- `seg` out 8: segments, active-low; `seg[7]`=dp, `seg[6:0]`=g..a.

## Operation
- Storage: two 4-entry sets, shadow and active, each entry {blank, dp, value}. Reset value of every entry: blank=1, dp=0, value=0.
- Accepted writes update the shadow entry `wr_digit` only.
- State: `slot` (2 bits), `cnt` (0..`REFRESH_DIV`-1), `pending` flag.
  - `cnt` increments every cycle. On `cnt`=`REFRESH_DIV`-1 it wraps to 0 and `slot` increments mod 4.
  - Frame wrap = the `cnt` wrap while `slot`=3.
- Phases within a slot: GUARD while `cnt` < `GUARD`, otherwise DRIVE.
  - GUARD: `an`=4'b1111, `seg`=8'hFF.
  - DRIVE: `an` = all ones except bit `slot`=0. `seg` = decode of active[slot].
  - If the entry's blank=1: `seg`=8'hFF in DRIVE, and `an` is still driven.
  - dp=1 clears `seg[7]`.
- Commit:
  - `commit` sets `pending`.
  - `wr_ready` = !`pending`. Writes stall while a commit is outstanding.
  - On a frame wrap with (`pending` || `commit`): active ← shadow, `pending` ← 0, `frame_done` = 1 for that cycle.
  - Write and `commit` in the same cycle (with `wr_ready`=1): the write is included in the committed frame. If that cycle is also the frame wrap, the swap uses the bypassed shadow value.
  - `commit` while `pending` already set has no extra effect.
- Reset mid-frame: all state returns to reset values on the next edge, including shadow and active. A pending commit is discarded.

## Timing
- Reset values: `an`=4'b1111, `seg`=8'hFF, `wr_ready`=1, `frame_done`=0, `slot`=0, `cnt`=0, `pending`=0.
- `an`, `seg` and `frame_done` are registered. They reflect the `slot`/`cnt` of the previous cycle, so output lag is 1 cycle.
- Cycle numbering: cycle k = k-th edge after `system1000_rst` deasserts.
  - Slot s drives during cycles s·D+G+1 … (s+1)·D, where D=`REFRESH_DIV` and G=`GUARD`.
  - Frame period is 4·D.
- Commit-to-display latency: at most 4·D+1 cycles.
- `wr_ready` falls the cycle after `commit` and rises the cycle after the swap.

## Structure
- Package `seg_pkg` holds:
  - the 16-entry hex→segment constant table (active-low, dp bit = 1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E;
  - the digit-entry record type;
  - `SEG_OFF`=8'hFF and `AN_OFF`=4'hF.
- Sub-module `seg_hex_decode`: combinational nibble + dp + blank → `seg`.

## Test plan
All scenarios use `REFRESH_DIV`=8, `GUARD`=2.

- **Reset:** hold reset 3 cycles → `an`=F, `seg`=FF, `wr_ready`=1. `an` stays F for cycles 1..2 and becomes E at cycle 3 with `seg`=FF (all entries blank).
- **Write and commit:** write digits 0..3 = 1,2,3,4 (dp on digit 2), then pulse `commit`.
  - `frame_done` pulses exactly once, at the next frame wrap.
  - Following frame: `an`=E/`seg`=F9, `an`=D/A4, `an`=B/30, `an`=7/99.
- **Stall:** `commit` then immediate `wr_valid` → `wr_ready`=0 until the swap, and the shadow is unchanged. After the swap the write is accepted.
- **Same-cycle wrap:** write and `commit` on the frame-wrap cycle → swap occurs that cycle and includes the new value. `frame_done`=1 on the next edge.
- **Guard:** across every slot boundary there are exactly 2 cycles of `an`=F, and never two `an` bits low at once.
- **Mid-frame reset:** reset asserted during slot 2 with a commit pending → outputs return to F/FF, `pending` is cleared, and the old digits are not displayed afterward.
